// File: rtl/up_counter.sv
// ----------------------------------------------------------------------------
// up_counter
//
// Purpose:
//   WIDTH-bit synchronous binary up-counter with an active-high count enable
//   and an asynchronous active-low clear. The count advances by one on each
//   rising edge of CLK while Up is high, and wraps modulo 2^WIDTH with no
//   carry-out or terminal-count flag. All bits are held in one register
//   clocked by CLK, so every bit updates on the same edge.
//
// Ports (positional order: clear_b, CLK, Up, A):
//   clear_b : input,  1 bit     - asynchronous clear, active low. While low,
//                                 A is forced to 0 and CLK/Up are ignored.
//   CLK     : input,  1 bit     - system clock, rising-edge active.
//   Up      : input,  1 bit     - count enable, sampled on the rising edge.
//   A       : output, WIDTH bit - current count, driven straight from the
//                                 state register.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module up_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clear_b,
    input  logic             CLK,
    input  logic             Up,
    output logic [WIDTH-1:0] A
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next-state value. The add truncates to WIDTH bits, which gives the
    // modulo-2^WIDTH wrap from all-ones back to zero for free.
    always_comb begin
        count_d = count_q;
        if (Up) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // State register. The clear is in the sensitivity list so that a falling
    // clear_b zeroes the count without waiting for a clock. An edge at which
    // clear_b is still sampled low takes the clear branch, so that edge never
    // counts.
    always_ff @(posedge CLK or negedge clear_b) begin
        if (!clear_b) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign A = count_q;

endmodule

// File: tb/tb_up_counter.sv
// ----------------------------------------------------------------------------
// tb_up_counter
//
// Directed testbench for up_counter (WIDTH = 4). A 10 ns clock has rising
// edges at 5, 15, 25, ... ns. Stimulus is applied at absolute times and the
// count is sampled 1 ns after edges (or after asynchronous events), against
// hand-computed expected values.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_up_counter;

    logic       clearB = 1'b1;
    logic       clk    = 1'b0;
    logic       up     = 1'b0;
    logic [3:0] countOut;

    int checks = 0;
    int errors = 0;

    up_counter #(.WIDTH(4)) dut (
        .clear_b (clearB),
        .CLK     (clk),
        .Up      (up),
        .A       (countOut)
    );

    // Free-running clock, rising edges at 5, 15, 25, ... ns.
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and log misses.
    task automatic checkOutput(input string tag, input logic [3:0] got,
                               input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t ns: got %0d expected %0d",
                     tag, $time, got, exp);
        end
    endtask

    // Drive both control inputs together.
    task automatic applyStimulus(input logic clearVal, input logic upVal);
        clearB = clearVal;
        up     = upVal;
    endtask

    // Advance simulation to an absolute time in ns.
    task automatic waitUntil(input int t);
        if ($time < t) #(t - $time);
    endtask

    initial begin
        // Power-up reset, held low across the edge at 5 ns.
        applyStimulus(1'b0, 1'b0);
        waitUntil(1);
        checkOutput("reset_t1", countOut, 4'd0);
        waitUntil(6);
        checkOutput("reset_edge5", countOut, 4'd0);
        waitUntil(9);
        checkOutput("reset_t9", countOut, 4'd0);

        // Release and count through a full wrap.
        waitUntil(10);
        applyStimulus(1'b1, 1'b1);
        waitUntil(16);
        checkOutput("count_first", countOut, 4'd1);
        waitUntil(86);
        checkOutput("count_mid", countOut, 4'd8);
        waitUntil(156);
        checkOutput("count_max", countOut, 4'd15);
        waitUntil(166);
        checkOutput("count_wrap", countOut, 4'd0);
        waitUntil(206);
        checkOutput("count_after_wrap", countOut, 4'd4);

        // Asynchronous clear between edges, held through the next edge.
        waitUntil(210);
        applyStimulus(1'b0, 1'b1);
        waitUntil(211);
        checkOutput("async_clear", countOut, 4'd0);
        waitUntil(216);
        checkOutput("clear_hold_edge", countOut, 4'd0);

        // Restart after clear.
        waitUntil(220);
        applyStimulus(1'b1, 1'b1);
        waitUntil(226);
        checkOutput("restart_first", countOut, 4'd1);
        waitUntil(306);
        checkOutput("restart_nine", countOut, 4'd9);

        // Bring the count to 5, then hold it with Up low.
        waitUntil(310);
        applyStimulus(1'b0, 1'b1);
        waitUntil(320);
        applyStimulus(1'b1, 1'b1);
        waitUntil(366);
        checkOutput("hold_setup", countOut, 4'd5);
        waitUntil(370);
        applyStimulus(1'b1, 1'b0);
        // A pulse on Up that lies entirely between edges must not count.
        waitUntil(371);
        up = 1'b1;
        waitUntil(373);
        up = 1'b0;
        waitUntil(376);
        checkOutput("hold_edge1", countOut, 4'd5);
        waitUntil(386);
        checkOutput("hold_edge2", countOut, 4'd5);
        waitUntil(396);
        checkOutput("hold_edge3", countOut, 4'd5);
        waitUntil(400);
        applyStimulus(1'b1, 1'b1);
        waitUntil(406);
        checkOutput("hold_resume", countOut, 4'd6);

        // Release coincident with a rising edge. The nonblocking update lands
        // after the edge has been sampled, so the counter sees clear_b low on
        // that edge, matching a simultaneous hardware transition.
        waitUntil(410);
        applyStimulus(1'b0, 1'b1);
        waitUntil(411);
        checkOutput("coinc_cleared", countOut, 4'd0);
        @(posedge clk);
        clearB <= 1'b1;
        waitUntil(416);
        checkOutput("coinc_edge", countOut, 4'd0);
        waitUntil(426);
        checkOutput("coinc_next", countOut, 4'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
